// File: rtl/ifetch_queue_pkg.sv
// Shared fetch-queue constants: address/data widths, reset PC and ring depth.
package ifetch_queue_pkg;

   localparam int INST_ADDR_WIDTH = 32;
   localparam int INST_DATA_WIDTH = 32;
   localparam int IFQ_DEPTH       = 4;

   localparam logic [INST_ADDR_WIDTH-1:0] CpuResetAddr = '0;

   // Pointer width for a ring of the given depth, including the wrap bit.
   function automatic int ifq_ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ifq_ring.sv
// Fetch ring storage: DEPTH entries of {addr, data, filled} with allocate,
// fill and read pointers. Each pointer carries a wrap bit so full and empty
// are distinguishable.
module ifq_ring
   import ifetch_queue_pkg::*;
#(
   parameter int ADDR_W = INST_ADDR_WIDTH,
   parameter int INST_W = INST_DATA_WIDTH,
   parameter int DEPTH  = IFQ_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   alloc,
   input  logic [ADDR_W-1:0]      alloc_addr,
   input  logic                   fill,
   input  logic [INST_W-1:0]      fill_data,
   input  logic                   pop,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic [$clog2(DEPTH):0] outstanding,
   output logic                   head_filled,
   output logic [ADDR_W-1:0]      head_addr,
   output logic [INST_W-1:0]      head_data
);

   localparam int IW = $clog2(DEPTH);
   localparam logic [IW:0] PTR_ONE = (IW+1)'(1);

   logic [IW:0]       wptr;
   logic [IW:0]       fptr;
   logic [IW:0]       rptr;
   logic [DEPTH-1:0]  filled;
   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [INST_W-1:0] data_mem [DEPTH];

   logic [IW-1:0] widx;
   logic [IW-1:0] fidx;
   logic [IW-1:0] ridx;

   assign widx        = wptr[IW-1:0];
   assign fidx        = fptr[IW-1:0];
   assign ridx        = rptr[IW-1:0];
   assign occupancy   = wptr - rptr;
   assign outstanding = wptr - fptr;
   assign head_filled = filled[ridx];
   assign head_addr   = addr_mem[ridx];
   assign head_data   = data_mem[ridx];

   // Pointers and filled bits; a flush collapses the ring onto the write pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr   <= '0;
         fptr   <= '0;
         rptr   <= '0;
         filled <= '0;
      end else if (flush) begin
         rptr   <= wptr;
         fptr   <= wptr;
         filled <= '0;
      end else begin
         if (alloc) begin
            filled[widx] <= 1'b0;
            wptr         <= wptr + PTR_ONE;
         end
         if (fill) begin
            filled[fidx] <= 1'b1;
            fptr         <= fptr + PTR_ONE;
         end
         if (pop) begin
            filled[ridx] <= 1'b0;
            rptr         <= rptr + PTR_ONE;
         end
      end
   end

   // Entry payload: address captured at allocation, instruction word at fill.
   always_ff @(posedge clk) begin
      if (alloc) begin
         addr_mem[widx] <= alloc_addr;
      end
      if (fill) begin
         data_mem[fidx] <= fill_data;
      end
   end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues in-order memory reads for the incoming PC,
// pairs responses with their PC in a small ring and hands them to decode.
// A jump flush empties the ring and counts in-flight reads to be discarded.
module ifetch_queue
   import ifetch_queue_pkg::*;
#(
   parameter int ADDR_W = INST_ADDR_WIDTH,
   parameter int INST_W = INST_DATA_WIDTH,
   parameter int DEPTH  = IFQ_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_i,
   output logic              pc_ready_o,
   input  logic              flush_i,
   output logic              mem_req_valid_o,
   output logic [ADDR_W-1:0] mem_req_addr_o,
   input  logic              mem_req_ready_i,
   input  logic              mem_rsp_valid_i,
   input  logic [INST_W-1:0] mem_rsp_data_i,
   output logic              inst_valid_o,
   output logic [INST_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_addr_o,
   input  logic              inst_ready_i
);

   localparam int CW = ifq_ptr_width(DEPTH);
   localparam logic [CW:0]   DEPTH_EXT = (CW+1)'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   logic [CW-1:0] occupancy;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] kill_cnt;
   logic [CW-1:0] kill_pending;
   logic [CW:0]   committed;
   logic          accept;
   logic          fill;
   logic          pop;
   logic          head_filled;
   logic [ADDR_W-1:0] head_addr;
   logic [INST_W-1:0] head_data;

   // Slots are consumed both by ring entries and by reads still to be killed.
   assign committed       = {1'b0, occupancy} + {1'b0, kill_cnt};
   assign mem_req_valid_o = !rst && !flush_i && (committed < DEPTH_EXT);
   assign mem_req_addr_o  = pc_i;
   assign accept          = mem_req_valid_o && mem_req_ready_i;
   assign pc_ready_o      = accept;

   assign fill = mem_rsp_valid_i && !rst && !flush_i &&
                 (kill_cnt == '0) && (outstanding != '0);

   assign inst_valid_o = !rst && !flush_i && head_filled && (occupancy != '0);
   assign pop          = inst_valid_o && inst_ready_i;
   assign inst_o       = inst_valid_o ? head_data : '0;
   assign inst_addr_o  = inst_valid_o ? head_addr : '0;

   assign kill_pending = kill_cnt + outstanding;

   // Track how many stale responses are still due after a flush and drop them.
   always_ff @(posedge clk) begin
      if (rst) begin
         kill_cnt <= '0;
      end else if (flush_i) begin
         if (mem_rsp_valid_i && (kill_pending != '0)) begin
            kill_cnt <= kill_pending - CNT_ONE;
         end else begin
            kill_cnt <= kill_pending;
         end
      end else if (mem_rsp_valid_i && (kill_cnt != '0)) begin
         kill_cnt <= kill_cnt - CNT_ONE;
      end
   end

   ifq_ring #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W),
      .DEPTH  (DEPTH)
   ) u_ring (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush_i),
      .alloc       (accept),
      .alloc_addr  (pc_i),
      .fill        (fill),
      .fill_data   (mem_rsp_data_i),
      .pop         (pop),
      .occupancy   (occupancy),
      .outstanding (outstanding),
      .head_filled (head_filled),
      .head_addr   (head_addr),
      .head_data   (head_data)
   );

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: a PC generator, an in-order memory
// model with programmable latency and a scoreboard of expected fetches.
module tb_ifetch_queue;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_i;
   logic        pc_ready_o;
   logic        flush_i;
   logic        mem_req_valid_o;
   logic [31:0] mem_req_addr_o;
   logic        mem_req_ready_i;
   logic        mem_rsp_valid_i;
   logic [31:0] mem_rsp_data_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic        inst_ready_i;

   int    vectors     = 0;
   int    miscompares = 0;
   int    cyc         = 0;
   int    mem_lat     = 1;
   bit    accepted_last = 1'b0;
   pend_t pend[$];
   logic [31:0] expq[$];

   ifetch_queue #(
      .ADDR_W (32),
      .INST_W (32),
      .DEPTH  (4)
   ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .pc_i            (pc_i),
      .pc_ready_o      (pc_ready_o),
      .flush_i         (flush_i),
      .mem_req_valid_o (mem_req_valid_o),
      .mem_req_addr_o  (mem_req_addr_o),
      .mem_req_ready_i (mem_req_ready_i),
      .mem_rsp_valid_i (mem_rsp_valid_i),
      .mem_rsp_data_i  (mem_rsp_data_i),
      .inst_valid_o    (inst_valid_o),
      .inst_o          (inst_o),
      .inst_addr_o     (inst_addr_o),
      .inst_ready_i    (inst_ready_i)
   );

   // Free-running clock.
   initial forever #5 clk = ~clk;

   // Memory contents: each word encodes its own address.
   function automatic logic [31:0] data_of(input logic [31:0] a);
      return 32'hC0DE_0000 | {16'h0000, a[15:0]};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // One clock: advance the PC after an accepted fetch and present the next
   // due memory response.
   task automatic applyStimulus(input int n);
      repeat (n) begin
         @(posedge clk);
         cyc++;
         #1;
         if (accepted_last) pc_i = pc_i + 32'd4;
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = data_of(pend[0].addr);
            void'(pend.pop_front());
         end else begin
            mem_rsp_valid_i = 1'b0;
            mem_rsp_data_i  = '0;
         end
      end
   endtask

   task automatic drain(input int n);
      mem_req_ready_i = 1'b0;
      inst_ready_i    = 1'b1;
      applyStimulus(n);
      #1;
   endtask

   // Scoreboard monitor and memory request recorder, sampled mid-cycle.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         expq.delete();
         pend.delete();
         accepted_last = 1'b0;
      end else begin
         if (inst_valid_o && inst_ready_i) begin
            if (expq.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL pop_unexpected actual_addr=0x%0h expected=none", inst_addr_o);
            end else begin
               logic [31:0] e;
               e = expq.pop_front();
               checkOutput("pop_addr", inst_addr_o, e);
               checkOutput("pop_data", inst_o, data_of(e));
            end
         end
         if (flush_i) expq.delete();
         accepted_last = pc_ready_o;
         if (pc_ready_o) begin
            pend_t p;
            p.addr = pc_i;
            p.due  = cyc + mem_lat;
            pend.push_back(p);
            expq.push_back(pc_i);
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; pc_i = '0; flush_i = 1'b0;
      mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0;
      inst_ready_i = 1'b1;
      applyStimulus(2);
      #1;
      checkOutput("rst_inst_valid", 32'(inst_valid_o), 32'd0);
      checkOutput("rst_req_valid", 32'(mem_req_valid_o), 32'd0);
      checkOutput("rst_pc_ready", 32'(pc_ready_o), 32'd0);
      checkOutput("rst_inst_addr", inst_addr_o, 32'h0);
      rst = 1'b0;

      // Streaming: one fetch and one instruction per cycle.
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1);
         #1;
         checkOutput("stream_pc_ready", 32'(pc_ready_o), 32'd1);
         if (i >= 1) checkOutput("stream_inst_valid", 32'(inst_valid_o), 32'd1);
      end
      drain(8);
      checkOutput("stream_drained_occ", 32'(u_dut.occupancy), 32'd0);

      // Backpressure until the ring is full, then release decode.
      pc_i = 32'h0; inst_ready_i = 1'b0; mem_req_ready_i = 1'b1;
      applyStimulus(3);
      #1;
      checkOutput("bp_req_valid_3", 32'(mem_req_valid_o), 32'd1);
      applyStimulus(1);
      #1;
      checkOutput("bp_req_valid_full", 32'(mem_req_valid_o), 32'd0);
      checkOutput("bp_pc_ready_full", 32'(pc_ready_o), 32'd0);
      applyStimulus(2);
      #1;
      checkOutput("bp_still_full", 32'(mem_req_valid_o), 32'd0);
      inst_ready_i = 1'b1;
      #1;
      checkOutput("bp_pop_cycle_no_issue", 32'(mem_req_valid_o), 32'd0);
      checkOutput("bp_head_addr", inst_addr_o, 32'h0);
      applyStimulus(1);
      #1;
      checkOutput("bp_issue_resumes", 32'(mem_req_valid_o), 32'd1);
      drain(8);

      // Flush with three slow reads in flight.
      mem_lat = 5; pc_i = 32'h40; inst_ready_i = 1'b0; mem_req_ready_i = 1'b1;
      applyStimulus(3);
      mem_req_ready_i = 1'b0;
      #1;
      checkOutput("fl_outstanding", 32'(u_dut.outstanding), 32'd3);
      flush_i = 1'b1; pc_i = 32'h100; mem_req_ready_i = 1'b1;
      applyStimulus(1);
      flush_i = 1'b0;
      #1;
      checkOutput("fl_kill_cnt", 32'(u_dut.kill_cnt), 32'd3);
      checkOutput("fl_occupancy", 32'(u_dut.occupancy), 32'd0);
      begin
         int waited;
         waited = 0;
         while (!inst_valid_o && waited < 20) begin
            applyStimulus(1);
            #1;
            waited++;
         end
      end
      checkOutput("fl_first_valid", 32'(inst_valid_o), 32'd1);
      checkOutput("fl_first_addr", inst_addr_o, 32'h100);
      checkOutput("fl_kill_done", 32'(u_dut.kill_cnt), 32'd0);
      drain(20);
      mem_lat = 1;
      drain(4);

      // Flush coincident with a response and a valid head.
      mem_lat = 2; pc_i = 32'h200; inst_ready_i = 1'b0; mem_req_ready_i = 1'b1;
      applyStimulus(3);
      mem_req_ready_i = 1'b0;
      #1;
      checkOutput("fc_head_valid", 32'(inst_valid_o), 32'd1);
      checkOutput("fc_head_addr", inst_addr_o, 32'h200);
      checkOutput("fc_outstanding", 32'(u_dut.outstanding), 32'd2);
      flush_i = 1'b1; inst_ready_i = 1'b1;
      #1;
      checkOutput("fc_valid_forced_low", 32'(inst_valid_o), 32'd0);
      applyStimulus(1);
      flush_i = 1'b0;
      #1;
      checkOutput("fc_kill_cnt", 32'(u_dut.kill_cnt), 32'd1);
      checkOutput("fc_occupancy", 32'(u_dut.occupancy), 32'd0);
      applyStimulus(1);
      #1;
      checkOutput("fc_kill_done", 32'(u_dut.kill_cnt), 32'd0);
      mem_lat = 1;
      drain(6);

      // Flush while the ring is full.
      pc_i = 32'h300; inst_ready_i = 1'b0; mem_req_ready_i = 1'b1;
      applyStimulus(6);
      #1;
      checkOutput("ff_occ_full", 32'(u_dut.occupancy), 32'd4);
      checkOutput("ff_kill_zero", 32'(u_dut.kill_cnt), 32'd0);
      flush_i = 1'b1; pc_i = 32'h400;
      #1;
      checkOutput("ff_req_valid_in_flush", 32'(mem_req_valid_o), 32'd0);
      applyStimulus(1);
      flush_i = 1'b0;
      #1;
      checkOutput("ff_occ_after", 32'(u_dut.occupancy), 32'd0);
      checkOutput("ff_req_valid_after", 32'(mem_req_valid_o), 32'd1);
      inst_ready_i = 1'b1;
      applyStimulus(6);
      drain(8);

      // Reset with two buffered entries.
      pc_i = 32'h500; inst_ready_i = 1'b0; mem_req_ready_i = 1'b1;
      applyStimulus(2);
      mem_req_ready_i = 1'b0;
      applyStimulus(1);
      #1;
      checkOutput("rm_occ_before", 32'(u_dut.occupancy), 32'd2);
      rst = 1'b1;
      applyStimulus(1);
      rst = 1'b0;
      #1;
      checkOutput("rm_inst_valid", 32'(inst_valid_o), 32'd0);
      checkOutput("rm_req_valid", 32'(mem_req_valid_o), 32'd1);
      checkOutput("rm_occupancy", 32'(u_dut.occupancy), 32'd0);
      pc_i = 32'h600; inst_ready_i = 1'b1; mem_req_ready_i = 1'b1;
      applyStimulus(6);
      drain(8);

      checkOutput("scoreboard_empty", 32'(expq.size()), 32'd0);
      checkOutput("memory_idle", 32'(pend.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
